// File: rtl/ifetch_buffer.sv
// Prefetch byte queue feeding the Y86-64 fetch stage with a 10-byte window at the PC.
// Optional IFETCH_BUF_PERF_EN adds perf_starve/perf_flush saturating counters.
//
// state   | meaning
// S_IDLE  | no request outstanding; issue when there is room
// S_BUSY  | request outstanding, data will be appended
// S_FLUSH | request outstanding after a redirect, data will be dropped (discard)
// S_FAULT | sticky error; no requests until redirect
module ifetch_buffer #(
   parameter int DEPTH_BYTES  = 24,
   parameter int IMEM_LAT_MAX = 15
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        redirect,
   input  logic [63:0] redirect_pc,
   output logic        imem_req,
   output logic [63:0] imem_addr,
   input  logic        imem_ack,
   input  logic [63:0] imem_rdata,
   input  logic        imem_err,
   output logic        win_valid,
   output logic [63:0] win_pc,
   output logic [79:0] win_bytes,
   output logic [4:0]  win_count,
   output logic        win_err,
   input  logic        consume,
   input  logic [3:0]  consume_len
`ifdef IFETCH_BUF_PERF_EN
   ,
   output logic [31:0] perf_starve,
   output logic [31:0] perf_flush
`endif
);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_FLUSH, S_FAULT} state_t;

   localparam int WDW = $clog2(IMEM_LAT_MAX + 1);
   localparam int AW  = $clog2(DEPTH_BYTES);

   state_t         state, state_nxt;
   logic [WDW-1:0] wd;
   logic [7:0]     q     [DEPTH_BYTES];
   logic [7:0]     q_nxt [DEPTH_BYTES];
   logic [63:0]    fetch_addr;
   logic [2:0]     drop;
   logic [4:0]     count_nxt;
   logic           do_issue, do_append, timeout, room;
   int             cons_n, app_n, base_n;

   assign imem_req  = (state == S_BUSY) || (state == S_FLUSH);
   assign win_err   = (state == S_FAULT);
   assign win_valid = (win_count >= 5'd10) || win_err;
   assign room      = (int'(win_count) + 8 <= DEPTH_BYTES);
   assign timeout   = imem_req && !imem_ack && (wd == WDW'(IMEM_LAT_MAX - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      do_issue  = 1'b0;
      do_append = 1'b0;
      case (state)
         S_IDLE: begin
            if (!redirect && room) begin
               state_nxt = S_BUSY;
               do_issue  = 1'b1;
            end
         end
         S_BUSY: begin
            if (redirect) state_nxt = imem_ack ? S_IDLE : S_FLUSH;
            else if (imem_ack) begin
               if (imem_err) state_nxt = S_FAULT;
               else begin
                  state_nxt = S_IDLE;
                  do_append = 1'b1;
               end
            end
            else if (timeout) state_nxt = S_FAULT;
         end
         S_FLUSH: begin
            if (imem_ack) state_nxt = S_IDLE;
            else if (timeout && !redirect) state_nxt = S_FAULT;
         end
         S_FAULT: begin
            if (redirect) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Queue is a shift register: head at index 0, consumed bytes shift out,
   // appended bytes land right after the survivors.
   always_comb begin
      cons_n = 0;
      if (consume && win_valid) begin
         cons_n = int'(consume_len);
         if (cons_n > 10) cons_n = 10;
         if (cons_n > int'(win_count)) cons_n = int'(win_count);
      end
      base_n = int'(win_count) - cons_n;
      app_n  = 0;
      for (int i = 0; i < DEPTH_BYTES; i++) begin
         q_nxt[i] = 8'h00;
         if (i + cons_n < DEPTH_BYTES) q_nxt[i] = q[AW'(i + cons_n)];
      end
      if (do_append) begin
         for (int j = 0; j < 8; j++) begin
            if (j >= int'(drop)) begin
               if (base_n + app_n < DEPTH_BYTES) q_nxt[AW'(base_n + app_n)] = imem_rdata[8*j +: 8];
               app_n = app_n + 1;
            end
         end
      end
      count_nxt = 5'(base_n + app_n);
   end

   always_comb begin
      win_bytes = '0;
      for (int k = 0; k < 10; k++) begin
         if (k < int'(win_count)) win_bytes[8*k +: 8] = q[k];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH_BYTES; i++) q[i] <= 8'h00;
         win_count  <= '0;
         win_pc     <= '0;
         fetch_addr <= '0;
         imem_addr  <= '0;
         drop       <= '0;
         wd         <= '0;
      end else begin
         if (do_issue) imem_addr <= fetch_addr;
         if (redirect || !imem_req || imem_ack) wd <= '0;
         else                                   wd <= wd + 1'b1;
         if (redirect) begin
            win_count  <= '0;
            win_pc     <= redirect_pc;
            fetch_addr <= {redirect_pc[63:3], 3'b000};
            drop       <= redirect_pc[2:0];
         end else begin
            q         <= q_nxt;
            win_count <= count_nxt;
            win_pc    <= win_pc + 64'(cons_n);
            if (do_append) begin
               fetch_addr <= fetch_addr + 64'd8;
               drop       <= 3'd0;
            end
         end
      end
   end

`ifdef IFETCH_BUF_PERF_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_starve <= '0;
         perf_flush  <= '0;
      end else begin
         if (!win_valid && !redirect && perf_starve != 32'hFFFF_FFFF) perf_starve <= perf_starve + 32'd1;
         if (redirect && imem_req && perf_flush != 32'hFFFF_FFFF) perf_flush <= perf_flush + 32'd1;
      end
   end
`endif

endmodule

// File: doc/ifetch_buffer.md
Name: ifetch_buffer

Overview:
- Byte-stream prefetch queue that sits directly upstream of the Y86-64 fetch stage. It reads aligned 8-byte words from instruction memory and gives the fetch logic a 10-byte window starting at the current PC, which covers the longest Y86 instruction.
- Fetch reports how many bytes it used. A taken branch, ret or mispredict redirects the stream.
- Replaces the direct byte-array read in the fetch stage, so instruction memory can take more than one cycle.

Parameters:
- DEPTH_BYTES, 24, queue capacity in bytes; must be at least 18.
- IMEM_LAT_MAX, 15, watchdog limit in cycles for an outstanding request. Exceeding it raises win_err.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- redirect, input, 1, one-cycle pulse that loads a new PC.
- redirect_pc, input, 64, new stream start address; any byte alignment.
- imem_req, output, 1, word read request; held until imem_ack.
- imem_addr, output, 64, word address; bits [2:0] are always 0; stable while imem_req=1.
- imem_ack, input, 1, read data valid this cycle.
- imem_rdata, input, 64, little-endian word; byte 0 is at imem_addr.
- imem_err, input, 1, qualified by imem_ack; the word is invalid.
- win_valid, output, 1, window is usable.
- win_pc, output, 64, address of win_bytes[7:0].
- win_bytes, output, 80, next 10 stream bytes; byte k is in [8k+7:8k]; only the first win_count bytes are meaningful.
- win_count, output, 5, number of valid bytes in the queue, 0..DEPTH_BYTES.
- win_err, output, 1, sticky fetch error.
- consume, input, 1, fetch accepted the instruction at win_pc.
- consume_len, input, 4, instruction length, 1..10.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - imem_req=0, imem_addr=0.
  - win_valid=0, win_pc=0, win_bytes=0, win_count=0, win_err=0.
  - Internal state: discard=0, watchdog=0.
- Issue rule:
  - Assert imem_req when all of the following hold: no request is outstanding, DEPTH_BYTES - win_count >= 8, and win_err=0.
  - The first request after reset is in the first cycle after rst_n rises, at address 0.
- Request handshake:
  - One outstanding request at most. imem_req and imem_addr stay constant until imem_ack.
  - A new request may be raised in the cycle after an ack, never in the same cycle.
- Append on ack (discard=0):
  - Bytes from the word are appended in address order.
  - For the first word after a redirect, the leading redirect_pc[2:0] bytes are dropped; later words append all 8 bytes.
  - imem_addr advances by 8.
- Window validity:
  - win_valid = (win_count >= 10) OR win_err.
  - win_bytes is taken from the queue head. Bytes at or beyond win_count read as 0.
- Consume:
  - Takes effect only when win_valid=1.
  - The head advances by consume_len and win_pc increments by consume_len; win_count decreases by consume_len.
  - consume_len=0 is a no-op. consume_len > min(10, win_count) clamps to min(10, win_count).
- Ack and consume in the same cycle: both apply. New win_count = old + appended - consumed.
- Redirect (has priority over consume and ack in the same cycle):
  - win_count=0, win_pc=redirect_pc, win_err cleared, watchdog cleared.
  - Fetch address becomes {redirect_pc[63:3], 3'b000}.
  - If a request is outstanding (including one acked in the same cycle), set discard=1. Keep imem_req/imem_addr until the ack, drop that ack's data, clear discard, then issue at the new address the next cycle.
  - A second redirect while discard=1 only updates the target.
- Errors (win_err is sticky until redirect; no further requests while set):
  - imem_err with imem_ack and discard=0 sets win_err; that word's data is not appended.
  - The watchdog counts cycles with imem_req=1. When it reaches IMEM_LAT_MAX it sets win_err and drops the request (imem_req=0). A later stray ack is ignored.
  - While win_err=1, win_valid=1, so fetch sees the remaining bytes plus the error and raises an instruction-memory-error status.
- Throughput: with a single-cycle memory, the stream sustains 8 bytes per 2 cycles.
- Reset asserted mid-request: everything clears immediately. The memory must tolerate a dropped req.

Optional Feature:
- Macro IFETCH_BUF_PERF_EN.
- Defined: adds 32-bit outputs perf_starve (cycles with win_valid=0 and no redirect) and perf_flush (redirect pulses that discarded an outstanding request).
  - Both saturate at 32'hFFFFFFFF and reset to 0.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
1. Reset release, 1-cycle-ack memory holding bytes 0x00..0x3F → req at 0x0 then 0x8. win_valid once win_count >= 10; win_pc=0, win_bytes=0x09080706050403020100.
2. Consume len 10, then 2, then 9, starting at PC 0 → win_pc goes 0x0→0xA→0xC→0x15. win_bytes[7:0] equals the address's byte each time; queue never exceeds 24.
3. Redirect to 0x23 while a 4-cycle ack is in flight → old ack discarded, next req at 0x20. First window at win_pc=0x23 with win_bytes[7:0]=0x23.
4. Ack with imem_err at 0x10 → win_err=1 and win_valid=1, no further req. Redirect to 0x40 clears win_err.
5. Memory never acks → after 15 req cycles, win_err=1 and imem_req=0.
6. Redirect, ack and consume in the same cycle → only the redirect takes effect; win_count=0, discard applied.
